// File: rtl/data_sram_like_bridge_pkg.sv
// Shared definitions for the sram-like bus bridges: FSM state encoding and bus size codes.
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_sram_size_enc.sv
// Maps a byte-write-enable pattern to bus direction, transfer size and the low address bits.
// Irregular write patterns fall back to a full-word write at the aligned address.
module sram_size_enc
  import data_sram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic       wr,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  always_comb begin
    wr      = |wen;
    size    = SIZE_WORD;
    addr_lo = 2'b00;
    case (wen)
      4'b0011: begin size = SIZE_HALF; addr_lo = 2'b00; end
      4'b1100: begin size = SIZE_HALF; addr_lo = 2'b10; end
      4'b0001: begin size = SIZE_BYTE; addr_lo = 2'b00; end
      4'b0010: begin size = SIZE_BYTE; addr_lo = 2'b01; end
      4'b0100: begin size = SIZE_BYTE; addr_lo = 2'b10; end
      4'b1000: begin size = SIZE_BYTE; addr_lo = 2'b11; end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Data-side bridge: turns the core's single-cycle SRAM request into one sram-like bus transaction,
// stalling the M stage until the bus reports completion and holding read data while the core is stalled.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            state, state_nxt;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        addr_lo;
  logic              complete;
  logic              unused_addr_bits;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (data_sram_en) state_nxt = ST_ADDR;
      ST_ADDR: if (data_addr_ok) state_nxt = data_data_ok ? ST_DONE : ST_DATA;
      ST_DATA: if (data_data_ok) state_nxt = ST_DONE;
      ST_DONE: if (!longest_stall) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data_req = (state == ST_ADDR);
    d_stall  = !rst && data_sram_en && (state != ST_DONE);
  end

  // Completion can arrive together with the address handshake, so both cases capture read data.
  assign complete = ((state == ST_ADDR) && data_addr_ok && data_data_ok) ||
                    ((state == ST_DATA) && data_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == ST_IDLE && data_sram_en) begin
        wen_q   <= data_sram_wen;
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
      end
      if (complete && wen_q == 4'b0000) rdata_q <= data_rdata;
    end
  end

  sram_size_enc u_size_enc (
    .wen     (wen_q),
    .wr      (data_wr),
    .size    (data_size),
    .addr_lo (addr_lo)
  );

  assign data_addr        = {addr_q[ADDR_W-1:2], addr_lo};
  assign data_wdata       = wdata_q;
  assign data_sram_rdata  = rdata_q;
  assign unused_addr_bits = ^addr_q[1:0];

endmodule
